// File: rtl/piso_shift_ctrl_pkg.sv
// rtl/piso_shift_ctrl_pkg.sv - shared types and defaults for the PISO shift sequencer
package piso_shift_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is unused and steers back to ST_IDLE on the next edge.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/piso_shift_ctrl_if.sv
// rtl/piso_shift_ctrl_if.sv - producer-side request and serial output bundle
interface piso_shift_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] din;
    logic             abort;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output start, din, abort,
        input  ready, sout, sout_valid, done, bit_cnt
    );

    modport slave (
        input  start, din, abort,
        output ready, sout, sout_valid, done, bit_cnt
    );
endinterface

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - WIDTH D-flop shift register with load, shift toward output and clear
module piso_shreg #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             CP,
    input  logic             n_rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Clear beats load beats shift; vacated positions fill with 0.
    always_comb begin
        shreg_d = shreg_q;
        if (clear_i) begin
            shreg_d = '0;
        end else if (load_i) begin
            shreg_d = din_i;
        end else if (shift_i) begin
            shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
        end
    end

    always_ff @(posedge CP or negedge n_rst) begin
        if (!n_rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q_o = shreg_q;

endmodule

// File: rtl/piso_shift_ctrl.sv
// rtl/piso_shift_ctrl.sv - IDLE/SHIFT/DONE sequencer, bit counter and output decode
module piso_shift_ctrl
    import piso_shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LSB_FIRST = 1
) (
    input  logic               CP,
    input  logic               n_rst,
    piso_shift_ctrl_if.slave   bus
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, shift, clear;
    logic [WIDTH-1:0] shreg;
    logic             out_bit;

    piso_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .CP      (CP),
        .n_rst   (n_rst),
        .load_i  (load),
        .shift_i (shift),
        .clear_i (clear),
        .din_i   (bus.din),
        .q_o     (shreg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort is ignored here, so start wins when both are high
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    shift = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                clear   = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CP or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_bit        = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
    assign bus.ready      = (state_q == ST_IDLE);
    assign bus.sout_valid = (state_q == ST_SHIFT);
    assign bus.sout       = (state_q == ST_SHIFT) & out_bit;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.bit_cnt    = cnt_q;

endmodule
